inst_fetch_unit: RTL

//  Instruction-fetch initiator for the word-indexed, combinational-read instruction memory.
//  - Holds the fetch PC and drives the memory word index.
//  - Captures each returned word with its PC into a small prefetch FIFO.
//  - Presents instructions to decode over a valid/ready handshake.
//  - Applies branch/jump redirects by flushing the FIFO and reloading the PC.

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_unit_if.sv | 28 ++
 rtl/inst_fetch_unit_fifo.sv | 76 +++++++
 rtl/inst_fetch_unit.sv | 68 ++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch definitions: widths, PC step, reset PC, NOP.
// Also the prefetch entry layout and the PC-to-word-index helper.
package inst_fetch_unit_pkg;

   localparam int          INST_W   = 32;
   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] pc_to_index(logic [31:0] pc);
      return pc >> 2;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch bus: memory word index/data and the decode handshake.
// master = fetch unit, slave = memory + decode side.
interface inst_fetch_unit_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   modport master (
      output imem_addr,
      input  imem_data,
      output out_valid,
      input  out_ready,
      output out_inst,
      output out_pc
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  out_valid,
      output out_ready,
      input  out_inst,
      input  out_pc
   );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, inst} entries with a registered head.
// The head register keeps its value while the FIFO is empty.
module inst_fetch_unit_fifo
   import inst_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_din,
   output fetch_entry_t o_dout,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_entry_t    r_mem [DEPTH];
   fetch_entry_t    r_dout;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;
   logic [CW-1:0]   w_cnt_nxt;
   logic [PW-1:0]   w_rd_nxt;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign w_cnt_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
   assign w_rd_nxt  = r_rd_ptr + PW'(1);
   assign o_dout    = r_dout;

   // Entry storage: write at the tail on every accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers and occupancy; flush empties the FIFO after any pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
         r_count <= w_cnt_nxt;
      end
   end

   // Head register: load the next head whenever it changes and exists.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout <= '0;
      end else if (!i_flush && (w_do_pop || o_empty)
                   && (w_cnt_nxt != '0)) begin
         r_dout <= (r_count > CW'(1)) ? r_mem[w_rd_nxt] : i_din;
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC register, memory index, prefetch FIFO,
// and redirect handling toward decode.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = inst_fetch_unit_pkg::RESET_PC,
   parameter int          FIFO_DEPTH = 2,
   parameter int          IMEM_AW    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_fetch_en,
   input  logic                      i_redirect_valid,
   input  logic [31:0]               i_redirect_pc,
   inst_fetch_unit_if.master         bus
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
       || IMEM_AW < 1 || IMEM_AW > 30) begin : g_bad_cfg
      $error("inst_fetch_unit: bad FIFO_DEPTH or IMEM_AW");
   end

   logic [31:0]  r_fetch_pc;
   logic [31:0]  w_redir_pc;
   logic         w_pop;
   logic         w_push;
   logic         w_full;
   logic         w_empty;
   fetch_entry_t w_din;
   fetch_entry_t w_dout;

   assign w_redir_pc = i_redirect_pc & ~32'd3;
   assign w_pop      = ~w_empty & bus.out_ready;
   assign w_push     = i_fetch_en & ~i_redirect_valid
                       & (~w_full | w_pop);
   assign w_din      = '{pc: r_fetch_pc, inst: bus.imem_data};

   assign bus.imem_addr = pc_to_index(r_fetch_pc);
   assign bus.out_valid = ~w_empty;
   assign bus.out_inst  = w_dout.inst;
   assign bus.out_pc    = w_dout.pc;

   // Fetch PC: redirect wins, otherwise step past each pushed word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
      end else if (i_redirect_valid) begin
         r_fetch_pc <= w_redir_pc;
      end else if (w_push) begin
         r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
   end

   inst_fetch_unit_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_redirect_valid),
      .i_din   (w_din),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule
